// File: rtl/basic_ram_pkg.sv
// ---------------------------------------------------------------------------
// basic_ram_pkg
// Shared definitions for the basic_ram_dp dual-port RAM slice.
//   ramState_e   : controller state (CLEAR sweep / READY for traffic)
//   BITS_PER_BYTE: width of one byte lane
//   byteCount()  : number of byte lanes in a word of a given width
// No ports (package).
// ---------------------------------------------------------------------------
package basic_ram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } ramState_e;

    localparam int BITS_PER_BYTE = 8;

    function automatic int byteCount(input int dataWidth);
        return dataWidth / BITS_PER_BYTE;
    endfunction

endpackage

// File: rtl/basic_ram_core.sv
// ---------------------------------------------------------------------------
// basic_ram_core
// Storage array with a byte-enabled write port and a registered read port.
// A read and a write to the same address in one cycle return the old word;
// any forwarding of the new data is the job of the instantiating block.
// Ports:
//   clock     : rising-edge clock
//   resetn    : synchronous active-low reset (read register only)
//   wrEn_i    : write strobe
//   wrAddr_i  : write address
//   wrData_i  : write data
//   wrBe_i    : per-byte write enable
//   rdEn_i    : read strobe; read register holds when low
//   rdAddr_i  : read address
//   rdData_o  : registered read data
// ---------------------------------------------------------------------------
module basic_ram_core
    import basic_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    wrEn_i,
    input  logic [ADDR_WIDTH-1:0]   wrAddr_i,
    input  logic [DATA_WIDTH-1:0]   wrData_i,
    input  logic [DATA_WIDTH/8-1:0] wrBe_i,
    input  logic                    rdEn_i,
    input  logic [ADDR_WIDTH-1:0]   rdAddr_i,
    output logic [DATA_WIDTH-1:0]   rdData_o
);

    localparam int NUM_BYTES = byteCount(DATA_WIDTH);
    localparam int DEPTH     = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdData_q;

    // The array itself is never reset; zeroing happens through ordinary
    // writes issued by the controller's clear sweep.
    always_ff @(posedge clock) begin
        if (wrEn_i) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
                if (wrBe_i[b]) begin
                    mem[wrAddr_i][b*BITS_PER_BYTE +: BITS_PER_BYTE] <= wrData_i[b*BITS_PER_BYTE +: BITS_PER_BYTE];
                end
            end
        end
    end

    // Read register samples the pre-write contents, giving read-first
    // behaviour on a same-address collision.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            rdData_q <= '0;
        end else if (rdEn_i) begin
            rdData_q <= mem[rdAddr_i];
        end
    end

    assign rdData_o = rdData_q;

endmodule

// File: rtl/basic_ram_dp.sv
// ---------------------------------------------------------------------------
// basic_ram_dp
// Simple dual-port RAM (one write port, one read port, one clock) that
// zeroes its whole array after every reset before accepting traffic.
// Optional macro BASIC_RAM_BYPASS_EN: when defined, a read colliding with a
// write to the same address returns the newly written bytes (write-first);
// when undefined it returns the old word (read-first).
// Ports:
//   clock     : rising-edge clock
//   resetn    : synchronous active-low reset
//   data      : write data
//   wraddress : write address
//   byteena   : per-byte write enable (bit i covers data[8i+7:8i])
//   wren      : write request
//   rdaddress : read address
//   rden      : read request
//   q         : read data, held between reads
//   q_valid   : q carries an accepted read this cycle
//   busy      : clear sweep in progress; requests ignored
// ---------------------------------------------------------------------------
module basic_ram_dp
    import basic_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 12,
    parameter int OUT_REG    = 0
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic [DATA_WIDTH-1:0]   data,
    input  logic [ADDR_WIDTH-1:0]   wraddress,
    input  logic [DATA_WIDTH/8-1:0] byteena,
    input  logic                    wren,
    input  logic [ADDR_WIDTH-1:0]   rdaddress,
    input  logic                    rden,
    output logic [DATA_WIDTH-1:0]   q,
    output logic                    q_valid,
    output logic                    busy
);

    localparam int NUM_BYTES = byteCount(DATA_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    ramState_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] clearCnt_q, clearCnt_d;
    logic                  valid1_q;

    logic                  wrAccept;
    logic                  rdAccept;
    logic                  coreWrEn;
    logic [ADDR_WIDTH-1:0] coreWrAddr;
    logic [DATA_WIDTH-1:0] coreWrData;
    logic [NUM_BYTES-1:0]  coreWrBe;
    logic [DATA_WIDTH-1:0] coreRdData;
    logic [DATA_WIDTH-1:0] mergedData;

    // State and clear-counter registers.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q    <= CLEAR;
            clearCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            clearCnt_q <= clearCnt_d;
        end
    end

    // The sweep writes one address per cycle and leaves CLEAR on the cycle
    // after the last address has been written.
    always_comb begin
        state_d    = state_q;
        clearCnt_d = clearCnt_q;
        case (state_q)
            CLEAR: begin
                clearCnt_d = clearCnt_q + 1'b1;
                if (clearCnt_q == LAST_ADDR) begin
                    state_d = READY;
                end
            end
            READY: begin
                state_d = READY;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    assign busy     = (state_q == CLEAR);
    assign wrAccept = !busy && wren;
    assign rdAccept = !busy && rden;

    // During the sweep the write port belongs to the clear counter.
    always_comb begin
        coreWrEn   = wrAccept;
        coreWrAddr = wraddress;
        coreWrData = data;
        coreWrBe   = byteena;
        if (busy) begin
            coreWrEn   = 1'b1;
            coreWrAddr = clearCnt_q;
            coreWrData = '0;
            coreWrBe   = '1;
        end
    end

    basic_ram_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) uCore (
        .clock    (clock),
        .resetn   (resetn),
        .wrEn_i   (coreWrEn),
        .wrAddr_i (coreWrAddr),
        .wrData_i (coreWrData),
        .wrBe_i   (coreWrBe),
        .rdEn_i   (rdAccept),
        .rdAddr_i (rdaddress),
        .rdData_o (coreRdData)
    );

`ifdef BASIC_RAM_BYPASS_EN
    logic                  bypHit_q;
    logic [DATA_WIDTH-1:0] bypData_q;
    logic [NUM_BYTES-1:0]  bypBe_q;

    // Capture collision info alongside the read so it lines up with the
    // core's read register; held between reads so q stays stable.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            bypHit_q  <= 1'b0;
            bypData_q <= '0;
            bypBe_q   <= '0;
        end else if (rdAccept) begin
            bypHit_q  <= wrAccept && (wraddress == rdaddress);
            bypData_q <= data;
            bypBe_q   <= byteena;
        end
    end

    // Overlay freshly written bytes onto the old word.
    always_comb begin
        mergedData = coreRdData;
        if (bypHit_q) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
                if (bypBe_q[b]) begin
                    mergedData[b*BITS_PER_BYTE +: BITS_PER_BYTE] = bypData_q[b*BITS_PER_BYTE +: BITS_PER_BYTE];
                end
            end
        end
    end
`else
    assign mergedData = coreRdData;
`endif

    // First-stage valid tracks the core's read register.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            valid1_q <= 1'b0;
        end else begin
            valid1_q <= rdAccept;
        end
    end

    generate
        if (OUT_REG != 0) begin : gOutReg
            logic [DATA_WIDTH-1:0] outData_q;
            logic                  valid2_q;

            // Extra output stage; data only advances with a valid read.
            always_ff @(posedge clock) begin
                if (!resetn) begin
                    outData_q <= '0;
                    valid2_q  <= 1'b0;
                end else begin
                    valid2_q <= valid1_q;
                    if (valid1_q) begin
                        outData_q <= mergedData;
                    end
                end
            end

            assign q       = outData_q;
            assign q_valid = valid2_q;
        end else begin : gNoOutReg
            assign q       = mergedData;
            assign q_valid = valid1_q;
        end
    endgenerate

endmodule

// File: tb/tb_basic_ram_dp.sv
// ---------------------------------------------------------------------------
// tb_basic_ram_dp
// Directed bench driving two instances (OUT_REG=0 and OUT_REG=1) with the
// same stimulus; expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_basic_ram_dp;

    localparam int DW = 16;
    localparam int AW = 12;

`ifdef BASIC_RAM_BYPASS_EN
    localparam logic [DW-1:0] EXP_COLL_FULL = 16'h2222;
    localparam logic [DW-1:0] EXP_COLL_PART = 16'h2244;
`else
    localparam logic [DW-1:0] EXP_COLL_FULL = 16'h1111;
    localparam logic [DW-1:0] EXP_COLL_PART = 16'h2222;
`endif

    logic          clock = 1'b0;
    logic          resetn;
    logic [DW-1:0] data;
    logic [AW-1:0] wraddress;
    logic [1:0]    byteena;
    logic          wren;
    logic [AW-1:0] rdaddress;
    logic          rden;
    logic [DW-1:0] q0, q1;
    logic          qv0, qv1, busy0, busy1;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    basic_ram_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_REG(0)) dut0 (
        .clock(clock), .resetn(resetn), .data(data), .wraddress(wraddress),
        .byteena(byteena), .wren(wren), .rdaddress(rdaddress), .rden(rden),
        .q(q0), .q_valid(qv0), .busy(busy0)
    );

    basic_ram_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_REG(1)) dut1 (
        .clock(clock), .resetn(resetn), .data(data), .wraddress(wraddress),
        .byteena(byteena), .wren(wren), .rdaddress(rdaddress), .rden(rden),
        .q(q1), .q_valid(qv1), .busy(busy1)
    );

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic applyStimulus(input logic wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                 input logic [1:0] be, input logic rd, input logic [AW-1:0] ra);
        wren      = wr;
        wraddress = wa;
        data      = wd;
        byteena   = be;
        rden      = rd;
        rdaddress = ra;
    endtask

    task automatic idle();
        applyStimulus(1'b0, '0, '0, 2'b00, 1'b0, '0);
    endtask

    task automatic writeWord(input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic [1:0] be);
        applyStimulus(1'b1, wa, wd, be, 1'b0, '0);
        tick();
        idle();
    endtask

    // One read (optionally with a concurrent write); checks both latencies
    // and that q holds once the read has passed.
    task automatic readCheck(input string tag, input logic wr, input logic [AW-1:0] wa,
                             input logic [DW-1:0] wd, input logic [1:0] be,
                             input logic [AW-1:0] ra, input logic [DW-1:0] expData);
        applyStimulus(wr, wa, wd, be, 1'b1, ra);
        tick();
        idle();
        checkOutput({tag, " q0"}, 32'(q0), 32'(expData));
        checkOutput({tag, " qv0"}, 32'(qv0), 32'd1);
        checkOutput({tag, " qv1 early"}, 32'(qv1), 32'd0);
        tick();
        checkOutput({tag, " qv0 after"}, 32'(qv0), 32'd0);
        checkOutput({tag, " q0 hold"}, 32'(q0), 32'(expData));
        checkOutput({tag, " q1"}, 32'(q1), 32'(expData));
        checkOutput({tag, " qv1"}, 32'(qv1), 32'd1);
    endtask

    // Counts cycles until busy drops; optionally pokes requests mid-sweep.
    task automatic waitClear(input string tag, input bit poke, input int expCycles);
        int cnt;
        cnt = 0;
        while (busy0 && cnt < 5000) begin
            if (poke && cnt == 100) applyStimulus(1'b1, 12'h010, 16'hAAAA, 2'b11, 1'b1, 12'h010);
            if (poke && cnt == 110) idle();
            tick();
            cnt++;
            if (poke && cnt > 100 && cnt <= 112) begin
                checkOutput({tag, " qv0 during clear"}, 32'(qv0), 32'd0);
                checkOutput({tag, " qv1 during clear"}, 32'(qv1), 32'd0);
            end
        end
        checkOutput({tag, " busy cycles"}, 32'(cnt), 32'(expCycles));
        checkOutput({tag, " busy1"}, 32'(busy1), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetn = 1'b0;
        idle();
        @(negedge clock);
        tick();
        tick();
        checkOutput("reset busy0", 32'(busy0), 32'd1);
        checkOutput("reset busy1", 32'(busy1), 32'd1);
        checkOutput("reset q0", 32'(q0), 32'd0);
        checkOutput("reset qv0", 32'(qv0), 32'd0);
        checkOutput("reset q1", 32'(q1), 32'd0);
        checkOutput("reset qv1", 32'(qv1), 32'd0);

        resetn = 1'b1;
        waitClear("clear1", 1'b1, 4096);

        readCheck("ignored write", 1'b0, '0, '0, 2'b00, 12'h010, 16'h0000);
        readCheck("addr 7FF", 1'b0, '0, '0, 2'b00, 12'h7FF, 16'h0000);

        writeWord(12'h123, 16'hBEEF, 2'b11);
        readCheck("beef", 1'b0, '0, '0, 2'b00, 12'h123, 16'hBEEF);
        writeWord(12'h123, 16'h1200, 2'b10);
        readCheck("upper byte", 1'b0, '0, '0, 2'b00, 12'h123, 16'h12EF);
        writeWord(12'h123, 16'hFFFF, 2'b00);
        readCheck("no byteena", 1'b0, '0, '0, 2'b00, 12'h123, 16'h12EF);

        writeWord(12'h200, 16'h1111, 2'b11);
        readCheck("collide full", 1'b1, 12'h200, 16'h2222, 2'b11, 12'h200, EXP_COLL_FULL);
        readCheck("after full", 1'b0, '0, '0, 2'b00, 12'h200, 16'h2222);
        readCheck("collide part", 1'b1, 12'h200, 16'h3344, 2'b01, 12'h200, EXP_COLL_PART);
        readCheck("after part", 1'b0, '0, '0, 2'b00, 12'h200, 16'h2244);

        readCheck("diff addr", 1'b1, 12'h300, 16'h5555, 2'b11, 12'h123, 16'h12EF);
        readCheck("diff addr wr", 1'b0, '0, '0, 2'b00, 12'h300, 16'h5555);

        writeWord(12'h001, 16'h0A01, 2'b11);
        writeWord(12'h002, 16'h0A02, 2'b11);
        writeWord(12'h003, 16'h0A03, 2'b11);

        // Fully pipelined back-to-back reads.
        applyStimulus(1'b0, '0, '0, 2'b00, 1'b1, 12'h001);
        tick();
        applyStimulus(1'b0, '0, '0, 2'b00, 1'b1, 12'h002);
        checkOutput("b2b q0 #1", 32'(q0), 32'h0A01);
        tick();
        applyStimulus(1'b0, '0, '0, 2'b00, 1'b1, 12'h003);
        checkOutput("b2b q0 #2", 32'(q0), 32'h0A02);
        checkOutput("b2b q1 #1", 32'(q1), 32'h0A01);
        tick();
        idle();
        checkOutput("b2b q0 #3", 32'(q0), 32'h0A03);
        checkOutput("b2b qv0 #3", 32'(qv0), 32'd1);
        checkOutput("b2b q1 #2", 32'(q1), 32'h0A02);
        tick();
        checkOutput("b2b q1 #3", 32'(q1), 32'h0A03);
        checkOutput("b2b qv1 #3", 32'(qv1), 32'd1);
        checkOutput("b2b qv0 done", 32'(qv0), 32'd0);
        tick();

        // Reset pulse in the middle of a read stream.
        applyStimulus(1'b0, '0, '0, 2'b00, 1'b1, 12'h001);
        tick();
        checkOutput("stream q0 #1", 32'(q0), 32'h0A01);
        applyStimulus(1'b0, '0, '0, 2'b00, 1'b1, 12'h002);
        resetn = 1'b0;
        tick();
        checkOutput("mid reset qv0", 32'(qv0), 32'd0);
        checkOutput("mid reset q0", 32'(q0), 32'd0);
        checkOutput("mid reset busy0", 32'(busy0), 32'd1);
        checkOutput("mid reset qv1", 32'(qv1), 32'd0);
        checkOutput("mid reset q1", 32'(q1), 32'd0);
        resetn = 1'b1;
        applyStimulus(1'b0, '0, '0, 2'b00, 1'b1, 12'h003);
        tick();
        idle();
        checkOutput("clear2 qv0", 32'(qv0), 32'd0);
        checkOutput("clear2 busy0", 32'(busy0), 32'd1);
        waitClear("clear2", 1'b0, 4095);

        readCheck("recleared 001", 1'b0, '0, '0, 2'b00, 12'h001, 16'h0000);
        readCheck("recleared 123", 1'b0, '0, '0, 2'b00, 12'h123, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
